// File: rtl/vec_seq_ctrl_if.sv
// Vector-memory and DUT-pair bus for the lockstep sequencer.
// master = sequencer, slave = memory plus golden/netlist DUT pair.
interface vec_seq_ctrl_if #(
    parameter int IN_W   = 59,
    parameter int OUT_W  = 360,
    parameter int ADDR_W = 5
);
    logic              vec_rd;
    logic [ADDR_W-1:0] vec_addr;
    logic [IN_W-1:0]   vec_data;
    logic [IN_W-1:0]   dut_in;
    logic [OUT_W-1:0]  y_ref;
    logic [OUT_W-1:0]  y_dut;

    modport master (
        output vec_rd, vec_addr, dut_in,
        input  vec_data, y_ref, y_dut
    );

    modport slave (
        input  vec_rd, vec_addr, dut_in,
        output vec_data, y_ref, y_dut
    );
endinterface

// File: rtl/vec_seq_ctrl.sv
// Lockstep differential-run sequencer: fetch vector, drive both DUTs,
// settle, compare y buses, count mismatches and build a MISR of y_ref.
module vec_seq_ctrl #(
    parameter int IN_W    = 59,
    parameter int OUT_W   = 360,
    parameter int NUM_VEC = 20,
    parameter int ADDR_W  = 5,
    parameter int SETTLE  = 2,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              stop_on_fail,
    vec_seq_ctrl_if.master    bus,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_idx,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [31:0]       signature
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_SAMPLE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int NSL   = (OUT_W + 31) / 32;
    localparam int PAD_W = NSL * 32;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [SET_W-1:0]  SET_LAST = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VEC - 1);
    localparam logic [31:0]       POLY     = 32'h04C11DB7;

    logic [2:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [SET_W-1:0]  scnt;
    logic [IN_W-1:0]   din_q;
    logic [PAD_W-1:0]  pad;
    logic [31:0]       fold;
    logic [31:0]       sig_next;
    logic              mism;

    assign bus.vec_rd   = (state == S_FETCH);
    assign bus.vec_addr = idx;
    assign bus.dut_in   = din_q;

    assign mism = (bus.y_ref != bus.y_dut);

    // Fold y_ref into 32 bits by XOR of zero-padded 32-bit slices
    always_comb begin
        pad = '0;
        pad[OUT_W-1:0] = bus.y_ref;
        fold = '0;
        for (int k = 0; k < NSL; k++) begin
            fold = fold ^ pad[k*32 +: 32];
        end
    end

    assign sig_next = {signature[30:0], 1'b0}
                    ^ (signature[31] ? POLY : 32'h0)
                    ^ fold;

    // Run sequencing, result capture and signature update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            scnt      <= '0;
            din_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_idx  <= '0;
            fail_cnt  <= '0;
            signature <= '0;
        end else if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        idx       <= '0;
                        fail      <= 1'b0;
                        fail_cnt  <= '0;
                        fail_idx  <= '0;
                        signature <= 32'hFFFF_FFFF;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    din_q <= bus.vec_data;
                    scnt  <= '0;
                    if (SETTLE > 0) begin
                        state <= S_SETTLE;
                    end else begin
                        state <= S_SAMPLE;
                    end
                end
                S_SETTLE: begin
                    if (scnt == SET_LAST) begin
                        state <= S_SAMPLE;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    signature <= sig_next;
                    if (mism) begin
                        fail <= 1'b1;
                        if (!fail) begin
                            fail_idx <= idx;
                        end
                        if (fail_cnt != '1) begin
                            fail_cnt <= fail_cnt + 1'b1;
                        end
                    end
                    if (idx == LAST_IDX || (mism && stop_on_fail)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
